// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and load sanitizer for the decimal counter slice.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // A non-decimal nibble loads as zero instead of creating an illegal digit.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? '0 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: load, or step up/down with 9->0 / 0->9 rollover.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t din,
  output bcd_digit_t q,
  output logic       is_max,
  output logic       is_min
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (step) begin
      if (up) q <= (q == BCD_MAX) ? '0 : q + 4'd1;
      else    q <= (q == '0) ? BCD_MAX : q - 4'd1;
    end
  end

  assign is_max = (q == BCD_MAX);
  assign is_min = (q == '0);

endmodule

// File: rtl/bcd_updown_cnt.sv
// Multi-decade packed-BCD up/down counter with load, terminal count and bad-load flag.
// Define BCD_CNT_SATURATE_EN to hold at all-9s/all-0s instead of wrapping.
module bcd_updown_cnt
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   out,
  output logic                  tc,
  output logic                  load_err
);

  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] bad;
  logic [DIGITS:0]   pre_max;
  logic [DIGITS:0]   pre_min;
  logic              cnt_en;

  // Digit i steps only when every lower digit sits at its rollover value.
  always_comb begin
    pre_max[0] = 1'b1;
    pre_min[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      pre_max[i+1] = pre_max[i] & is_max[i];
      pre_min[i+1] = pre_min[i] & is_min[i];
    end
  end

  always_comb begin
    step = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = cnt_en & (up ? pre_max[i] : pre_min[i]);
    end
  end

  assign tc = en & (up ? pre_max[DIGITS] : pre_min[DIGITS]);

`ifdef BCD_CNT_SATURATE_EN
  // At the end of range tc is exactly the condition that would wrap.
  assign cnt_en = en & ~tc;
`else
  assign cnt_en = en;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_t din;

    assign bad[i] = (load_val[BCD_W*i +: BCD_W] > BCD_MAX);
    assign din    = bcd_sanitize(load_val[BCD_W*i +: BCD_W]);

    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (step[i]),
      .up     (up),
      .load   (load),
      .din    (din),
      .q      (out[BCD_W*i +: BCD_W]),
      .is_max (is_max[i]),
      .is_min (is_min[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) load_err <= 1'b0;
    else      load_err <= load & (|bad);
  end

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// Self-checking bench for bcd_updown_cnt against an integer-valued decimal model.
module tb_bcd_updown_cnt;

  localparam int D    = 4;
  localparam int W    = 4 * D;
  localparam int MAXV = 9999;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] out;
  logic         tc;
  logic         load_err;

  int n_checks = 0;
  int n_fail   = 0;

  int mval = 0;
  bit merr = 1'b0;

  bcd_updown_cnt #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .tc       (tc),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit model_tc();
    return en && (up ? (mval == MAXV) : (mval == 0));
  endfunction

  task automatic apply(input bit ld, input logic [W-1:0] lv, input bit e, input bit u);
    load = ld; load_val = lv; en = e; up = u;
  endtask

  // Advance the model from the driven inputs, then clock the DUT.
  task automatic tick();
    int nv;
    bit ne;
    int p;
    int nib;
    nv = mval;
    ne = 1'b0;
    if (load) begin
      nv = 0;
      p = 1;
      for (int i = 0; i < D; i++) begin
        nib = int'(load_val[4*i +: 4]);
        if (nib > 9) begin
          nib = 0;
          ne = 1'b1;
        end
        nv += nib * p;
        p *= 10;
      end
    end else if (en) begin
`ifdef BCD_CNT_SATURATE_EN
      if (up) nv = (mval == MAXV) ? MAXV : mval + 1;
      else    nv = (mval == 0) ? 0 : mval - 1;
`else
      if (up) nv = (mval + 1) % (MAXV + 1);
      else    nv = (mval + MAXV) % (MAXV + 1);
`endif
    end
    @(posedge clk);
    #1;
    mval = nv;
    merr = ne;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply(0, '0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %h want %h", out, 16'h0);
    end
    n_checks++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_load_err: got %b want 0", load_err);
    end
    n_checks++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tc_down: got %b want 1", tc);
    end
    up = 1'b1;
    #1;
    n_checks++;
    if (tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tc_up: got %b want 0", tc);
    end
    rst = 1'b1;
    mval = 0;
    merr = 1'b0;
    apply(0, '0, 0, 0);
  endtask

  task automatic test_count_up();
    apply(1, 16'h9998, 0, 1);
    tick();
    apply(0, '0, 1, 1);
    #1;
    n_checks++;
    if (tc !== 1'b0) begin
      n_fail++;
      $display("FAIL up_tc_9998: got %b want 0", tc);
    end
    tick();
    n_checks++;
    if (out !== 16'h9999) begin
      n_fail++;
      $display("FAIL up_9999: got %h want 9999", out);
    end
    n_checks++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL up_tc_9999: got %b want 1", tc);
    end
    tick();
    n_checks++;
    if (out !== to_bcd(mval)) begin
      n_fail++;
      $display("FAIL up_wrap: got %h want %h", out, to_bcd(mval));
    end
    n_checks++;
    if (tc !== model_tc()) begin
      n_fail++;
      $display("FAIL up_tc_after_wrap: got %b want %b", tc, model_tc());
    end
  endtask

  task automatic test_count_down();
    apply(1, 16'h1000, 0, 0);
    tick();
    apply(0, '0, 1, 0);
    tick();
    n_checks++;
    if (out !== 16'h0999) begin
      n_fail++;
      $display("FAIL down_0999: got %h want 0999", out);
    end
    tick();
    n_checks++;
    if (out !== 16'h0998) begin
      n_fail++;
      $display("FAIL down_0998: got %h want 0998", out);
    end
    apply(1, 16'h0000, 0, 0);
    tick();
    apply(0, '0, 1, 0);
    #1;
    n_checks++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL down_tc_0000: got %b want 1", tc);
    end
    tick();
    n_checks++;
    if (out !== to_bcd(mval)) begin
      n_fail++;
      $display("FAIL down_wrap: got %h want %h", out, to_bcd(mval));
    end
  endtask

  task automatic test_invalid_load();
    apply(1, 16'h12A4, 1, 1);
    tick();
    n_checks++;
    if (out !== 16'h1204) begin
      n_fail++;
      $display("FAIL bad_load_out: got %h want 1204", out);
    end
    n_checks++;
    if (load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_load_err_set: got %b want 1", load_err);
    end
    apply(0, '0, 0, 1);
    tick();
    n_checks++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_load_err_clear: got %b want 0", load_err);
    end
    apply(1, 16'h0937, 0, 1);
    tick();
    n_checks++;
    if (load_err !== 1'b0 || out !== 16'h0937) begin
      n_fail++;
      $display("FAIL good_load: got %h/%b want 0937/0", out, load_err);
    end
  endtask

  task automatic test_priority();
    apply(1, 16'h0500, 0, 1);
    tick();
    apply(1, 16'h0042, 1, 1);
    tick();
    n_checks++;
    if (out !== 16'h0042) begin
      n_fail++;
      $display("FAIL load_priority: got %h want 0042", out);
    end
  endtask

  task automatic test_async_reset();
    apply(1, 16'h0357, 0, 1);
    tick();
    apply(0, '0, 1, 1);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0000", out);
    end
    mval = 0;
    merr = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if (out !== 16'h0001) begin
      n_fail++;
      $display("FAIL post_reset_count: got %h want 0001", out);
    end
  endtask

  task automatic test_direction();
    logic [W-1:0] exp_seq [3];
    exp_seq[0] = 16'h0011;
    exp_seq[1] = 16'h0010;
    exp_seq[2] = 16'h0009;
    apply(1, 16'h0010, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(0, '0, 1, (i == 0));
      tick();
      n_checks++;
      if (out !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL dir_toggle_%0d: got %h want %h", i, out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] lv;
    int r;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      lv = W'($urandom);
      if (r < 4)       apply(1, 16'h9999, 0, 1);
      else if (r < 8)  apply(1, 16'h0000, 0, 0);
      else if (r < 16) apply(1, lv, $urandom_range(0, 1), $urandom_range(0, 1));
      else             apply(0, lv, ($urandom_range(0, 9) < 8), $urandom_range(0, 1));
      #1;
      n_checks++;
      if (tc !== model_tc()) begin
        n_fail++;
        $display("FAIL rand_tc_%0d: got %b want %b", it, tc, model_tc());
      end
      tick();
      n_checks++;
      if (out !== to_bcd(mval) || load_err !== merr) begin
        n_fail++;
        $display("FAIL rand_state_%0d: got %h/%b want %h/%b", it, out, load_err, to_bcd(mval), merr);
      end
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_count_up();
    test_count_down();
    test_invalid_load();
    test_priority();
    test_async_reset();
    test_direction();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_cnt.md
# bcd_updown_cnt

Parametrised multi-digit packed-BCD counter with count-up/count-down, synchronous parallel load, terminal-count output and invalid-load detection. It is the general-purpose decimal counter for display, timer and event-count paths, and replaces fixed four-digit up-only chains. All digits update on the same clock edge. The carry/borrow between digits is resolved combinationally within the cycle.

## Interface
Parameters:
- DIGITS, 4, number of BCD decades (1..8); the count width is 4*DIGITS.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; one step per clock while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load; has priority over en.
- load_val  in  4*DIGITS  packed BCD load value; digit i is in bits [4i+3:4i].
- out  out  4*DIGITS  current count, packed BCD, registered.
- tc  out  1  terminal count, combinational.
- load_err  out  1  registered one-cycle flag: the last load contained a non-BCD digit.

## Operation
- Reset (rst low, asynchronous): out = 0, load_err = 0. tc follows from out, so it is 1 if en=1 and up=0, otherwise 0.
- Priority on each edge is rst, then load, then en, then hold.
- Load:
  - Each digit of load_val greater than 9 is replaced by 0. Valid digits load unchanged.
  - load_err = 1 on the next cycle if any digit was replaced, otherwise 0.
  - en is ignored in a load cycle.
- Count up:
  - Digit 0 steps when en=1.
  - Digit i (i>0) steps when en=1 and digits 0..i-1 are all 9.
  - A stepping digit goes 9->0, otherwise +1.
- Count down:
  - Digit 0 steps when en=1.
  - Digit i (i>0) steps when en=1 and digits 0..i-1 are all 0.
  - A stepping digit goes 0->9, otherwise -1.
- Wrap-around (default build): all-9s + up -> all-0s; all-0s + down -> all-9s.
- tc = en & (up ? all digits 9 : all digits 0). It reflects the current state, so it is high in the cycle whose edge produces the wrap or hold.
- load_err clears to 0 on any non-load cycle.
- Digits never hold values above 9 by construction. No other illegal states exist.
- A direction change takes effect on the next enabled edge. The counter has no direction state.

## Timing
- out has one-cycle latency: inputs sampled at edge k appear on out after edge k.
- tc is combinational from out, en and up. It is valid in the same cycle, with no added latency.
- load_err is registered and asserts on the cycle after the offending load edge, aligned with the loaded out.
- rst asserted mid-count forces out = 0 immediately, without waiting for clk. Counting resumes on the first edge after rst deasserts with en=1.
- The worst-case path is the DIGITS-deep all-9/all-0 enable chain. It must close at system clock for DIGITS=8.

## Configuration
- BCD_CNT_SATURATE_EN defined:
  - At all-9s with up=1 and en=1, out holds at all-9s.
  - At all-0s with up=0 and en=1, out holds at all-0s.
  - tc still asserts in those cycles. Load behaviour is unchanged.
- Undefined: the counter wraps as described in Operation.

## Structure
- Package bcd_pkg holds:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - a bcd_digit_t typedef
  - the function bcd_sanitize (digit > 9 -> 0).
- Sub-module bcd_digit is one decade with inputs clk, rst, step, up, load, din, and outputs q, is_max (q==9) and is_min (q==0).
- The top level instantiates DIGITS copies in a generate loop. It forms the step chain from the is_max/is_min AND-prefix, and implements tc, saturation and load_err.

## Test plan
- Reset then count up, DIGITS=4: load 9998, en=1, up=1 -> out 9999 with tc=1, then 0000 with tc=0. In the saturate build out stays at 9999.
- Count down across decades: load 1000, en=1, up=0 -> 0999, 0998; from 0000 the next value is 9999 (wrap build), with tc=1 in the 0000 cycle.
- Invalid load: load_val 0x12A4 -> out 1204 and load_err=1 for exactly one cycle; the next cycle with load=0 gives load_err=0.
- Load-vs-count priority: out 0500, load=1, load_val 0042, en=1 in the same cycle -> out 0042, not 0043.
- Asynchronous reset mid-count: drive rst low between edges while out=0357 -> out=0000 before the next edge; rst high with en=1 -> 0001 after the first edge.
- Direction toggle: out 0010, up=1 for one edge, then up=0 for two edges -> 0011, 0010, 0009.
